fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 114 +++++++++++
 tb/tb_fifo_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// Read-side adapter: pulls words from a FIFO with 1-cycle read latency into a
// 2-entry valid/ready output buffer. Optional FIFO_READER_CNT_EN adds a handshake counter.
module fifo_reader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             rd_clk_i,
  input  logic             clr_n_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  input  logic             fifo_rd_error_i,
  output logic             fifo_rd_en_o,
  input  logic             flush_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             err_o
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [15:0]      rd_count_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t             r_occ;
  logic             r_inflight;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             r_err;
  logic             w_pop;
  logic             w_wr;
  logic [2:0]       w_level;

  assign w_pop   = m_valid_o && m_ready_i;
  assign w_wr    = r_inflight && !flush_i;
  // Occupancy plus the word already on its way, minus the one leaving now.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign fifo_rd_en_o = clr_n_i && !fifo_empty_i && !flush_i && (w_level < 3'd2);
  assign m_valid_o    = (r_occ != EMPTY);
  assign m_data_o     = r_head;
  assign err_o        = r_err;

  always_ff @(posedge rd_clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      r_occ      <= EMPTY;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en_o && !fifo_empty_i;
      if (fifo_rd_error_i) begin
        r_err <= 1'b1;
      end
      if (flush_i) begin
        r_occ <= EMPTY;
      end else begin
        unique case (r_occ)
          EMPTY: begin
            if (w_wr) begin
              r_head <= fifo_rdata_i;
              r_occ  <= ONE;
            end
          end
          ONE: begin
            if (w_wr && w_pop) begin
              r_head <= fifo_rdata_i;
            end else if (w_wr) begin
              r_tail <= fifo_rdata_i;
              r_occ  <= TWO;
            end else if (w_pop) begin
              r_occ <= EMPTY;
            end
          end
          TWO: begin
            if (w_pop) begin
              r_head <= r_tail;
              if (w_wr) begin
                r_tail <= fifo_rdata_i;
              end else begin
                r_occ <= ONE;
              end
            end
          end
          default: r_occ <= EMPTY;
        endcase
      end
    end
  end

  // The read gate keeps occupancy + in-flight <= 2, so TWO never sees a write without a pop.
  a_no_overflow: assert property (@(posedge rd_clk_i) disable iff (!clr_n_i)
    !((r_occ == TWO) && w_wr && !w_pop));

`ifdef FIFO_READER_CNT_EN
  logic [15:0] r_count;

  assign rd_count_o = r_count;

  always_ff @(posedge rd_clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      r_count <= '0;
    end else if (w_pop && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed self-checking bench for fifo_reader with a small FIFO model (1-cycle read latency).
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       fifo_empty;
  logic [7:0] fifo_rdata = 8'hEE;
  logic       rd_err;
  logic       fifo_rd_en;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       err;
`ifdef FIFO_READER_CNT_EN
  logic [15:0] rd_count;
`endif

  always #5 clk = ~clk;

  fifo_reader #(.WIDTH(8)) dut (
    .rd_clk_i        (clk),
    .clr_n_i         (clr_n),
    .fifo_empty_i    (fifo_empty),
    .fifo_rdata_i    (fifo_rdata),
    .fifo_rd_error_i (rd_err),
    .fifo_rd_en_o    (fifo_rd_en),
    .flush_i         (flush),
    .m_valid_o       (m_valid),
    .m_ready_i       (m_ready),
    .m_data_o        (m_data),
    .err_o           (err)
`ifdef FIFO_READER_CNT_EN
    ,
    .rd_count_o      (rd_count)
`endif
  );

  logic [7:0] fmem [256];
  logic [7:0] f_wp = '0;
  logic [7:0] f_rp = '0;
  logic       f_skip = 1'b0;
  logic       f_inf = 1'b0;

  assign fifo_empty = !f_inf && (f_wp == f_rp);

  always @(posedge clk) begin
    if (f_skip) begin
      f_rp       <= f_wp;
      fifo_rdata <= 8'hEE;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_rdata <= fmem[f_rp];
      f_rp       <= f_rp + 8'd1;
    end else begin
      fifo_rdata <= 8'hEE;
    end
  end

  int unsigned n_viol = 0;
  always @(negedge clk) begin
    if (fifo_rd_en && fifo_empty) n_viol++;
  end

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    fmem[f_wp] = d;
    f_wp = f_wp + 8'd1;
  endtask

  task automatic drop();
    f_skip = 1'b1;
    nxt();
    f_skip = 1'b0;
  endtask

  logic [5:0] e_rd = 6'b000111;
  logic [5:0] e_v  = 6'b011100;
  logic [7:0] e_d [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
  logic [7:0] got [8];
  int unsigned ng;
  int unsigned nc;
  int unsigned n_rd;
  int unsigned n_v;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_n = 1'b0; flush = 1'b0; m_ready = 1'b0; rd_err = 1'b0;
    push(8'hAA);
    smp();
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_err", err, 0);
    drop();
    clr_n = 1'b1;
`ifdef FIFO_READER_CNT_EN
    chk("cnt_rst", rd_count, 0);
`endif

    // Basic streaming: three words, ready held high
    nxt();
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    for (int c = 0; c < 6; c++) begin
      if (c != 0) nxt();
      smp();
      chk($sformatf("s_rd_c%0d", c), fifo_rd_en, e_rd[c]);
      chk($sformatf("s_v_c%0d", c), m_valid, e_v[c]);
      if (e_v[c]) chk($sformatf("s_d_c%0d", c), m_data, e_d[c]);
    end
`ifdef FIFO_READER_CNT_EN
    chk("cnt_3", rd_count, 3);
`endif

    // Backpressure: five words, ready low
    nxt();
    m_ready = 1'b0;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05);
    n_rd = 0;
    for (int c = 0; c < 7; c++) begin
      if (c != 0) nxt();
      smp();
      if (fifo_rd_en) n_rd++;
      if (c == 6) begin
        chk("bp_valid", m_valid, 1);
        chk("bp_hold", m_data, 8'h01);
      end
    end
    chk("bp_reads", n_rd, 2);
    nxt();
    m_ready = 1'b1;
    ng = 0; nc = 0;
    for (int c = 0; c < 20 && ng < 5; c++) begin
      if (c != 0) nxt();
      smp();
      nc++;
      if (m_valid) begin
        got[ng] = m_data;
        ng++;
      end
    end
    chk("bp_count", ng, 5);
    chk("bp_cycles", nc, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("bp_word%0d", i), got[i], i + 1);
    nxt();
    smp();
    chk("bp_done", m_valid, 0);

    // FIFO empty throughout
    n_rd = 0; n_v = 0;
    for (int c = 0; c < 10; c++) begin
      nxt();
      smp();
      if (fifo_rd_en) n_rd++;
      if (m_valid) n_v++;
    end
    chk("empty_rd", n_rd, 0);
    chk("empty_valid", n_v, 0);

    // Flush with a word in flight
    nxt();
    m_ready = 1'b0;
    push(8'h41); push(8'h42); push(8'h43);
    nxt(); nxt();
    flush = 1'b1;
    smp();
    chk("fl_rd_blocked", fifo_rd_en, 0);
    chk("fl_pre_valid", m_valid, 1);
    chk("fl_pre_data", m_data, 8'h41);
    nxt();
    flush = 1'b0;
    smp();
    chk("fl_valid0", m_valid, 0);
    m_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 10; c++) begin
      nxt();
      smp();
      if (m_valid && ng < 8) begin
        got[ng] = m_data;
        ng++;
      end
    end
    chk("fl_count", ng, 1);
    chk("fl_word", got[0], 8'h43);

    // Flush while buffer full
    nxt();
    m_ready = 1'b0;
    push(8'h51); push(8'h52);
    nxt(); nxt(); nxt();
    smp();
    chk("fl2_pre", m_data, 8'h51);
    nxt();
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    smp();
    chk("fl2_valid0", m_valid, 0);
    m_ready = 1'b1;
    n_v = 0;
    for (int c = 0; c < 5; c++) begin
      nxt();
      smp();
      if (m_valid) n_v++;
    end
    chk("fl2_none", n_v, 0);

    // Sticky error, flush does not clear it, async reset does
    nxt();
    rd_err = 1'b1;
    nxt();
    rd_err = 1'b0;
    smp();
    chk("err_set", err, 1);
    nxt();
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    m_ready = 1'b0;
    push(8'h61); push(8'h62);
    smp();
    nxt(); nxt();
    smp();
    chk("err_after_flush", err, 1);
    chk("mid_valid", m_valid, 1);
    #1;
    clr_n = 1'b0;
    #1;
    chk("async_err", err, 0);
    chk("async_valid", m_valid, 0);
    chk("async_data", m_data, 0);
    chk("async_rd_en", fifo_rd_en, 0);
    drop();
    clr_n = 1'b1;
    m_ready = 1'b1;
    push(8'h77);
    smp();
    chk("post_rd", fifo_rd_en, 1);
    nxt();
    smp();
    chk("post_v1", m_valid, 0);
    nxt();
    smp();
    chk("post_v2", m_valid, 1);
    chk("post_data", m_data, 8'h77);

`ifdef FIFO_READER_CNT_EN
    nxt();
    f_inf = 1'b1;
    m_ready = 1'b1;
    repeat (70000) nxt();
    smp();
    chk("cnt_sat", rd_count, 16'hFFFF);
    #1;
    clr_n = 1'b0;
    #1;
    chk("cnt_clr", rd_count, 0);
    f_inf = 1'b0;
    drop();
    clr_n = 1'b1;
`endif

    nxt();
    chk("rd_en_while_empty", n_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
